// File: rtl/main_mem_ctrl_if.sv
// Request/response bundle between the cache controller (master) and main memory (slave).
interface main_mem_ctrl_if #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int BLOCK_WORDS = 4
);
    logic                          rd_req;
    logic                          wr_req;
    logic [ADDR_W-1:0]             addr;
    logic [DATA_W-1:0]             wr_data;
    logic [DATA_W*BLOCK_WORDS-1:0] rd_block;
    logic                          ready;
    logic                          busy;

    modport master (
        output rd_req, wr_req, addr, wr_data,
        input  rd_block, ready, busy
    );

    modport slave (
        input  rd_req, wr_req, addr, wr_data,
        output rd_block, ready, busy
    );
endinterface

// File: rtl/main_mem_ctrl.sv
// Backing main memory: block fills and word stores, each completing a fixed LATENCY cycles after acceptance.
//   state   | meaning
//   IDLE    | waiting for rd_req / wr_req (write has priority)
//   RD_WAIT | block fill in flight, rd_block loaded at completion
//   WR_WAIT | word store in flight, memory written at completion
module main_mem_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int LATENCY     = 4
) (
    input  logic          clk,
    input  logic          reset,
    main_mem_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

    state_t                        state;
    logic [CNT_W-1:0]              count;
    logic [ADDR_W-1:0]             addr_q;
    logic [DATA_W-1:0]             data_q;
    logic                          busy_q;
    logic                          ready_q;
    logic [DATA_W*BLOCK_WORDS-1:0] block_q;
    logic [DATA_W-1:0]             mem [DEPTH];
    logic                          done;
    logic                          mem_we;

    assign done   = (count == CNT_W'(LATENCY));
    assign mem_we = (state == WR_WAIT) && done;

    // Each word powers up holding its own index; reset never touches the array.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [DATA_W-1:0] word_q = DATA_W'(i);

        always_ff @(posedge clk) begin
            if (mem_we && (addr_q == ADDR_W'(i))) begin
                word_q <= data_q;
            end
        end

        assign mem[i] = word_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            block_q <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wr_req) begin
                        addr_q <= bus.addr;
                        data_q <= bus.wr_data;
                        state  <= WR_WAIT;
                        busy_q <= 1'b1;
                        count  <= CNT_W'(1);
                    end else if (bus.rd_req) begin
                        addr_q <= bus.addr & ALIGN_MASK;
                        state  <= RD_WAIT;
                        busy_q <= 1'b1;
                        count  <= CNT_W'(1);
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (done) begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        count   <= '0;
                        if (state == RD_WAIT) begin
                            for (int k = 0; k < BLOCK_WORDS; k++) begin
                                block_q[k*DATA_W +: DATA_W] <= mem[addr_q + ADDR_W'(k)];
                            end
                        end
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.ready    = ready_q;
    assign bus.rd_block = block_q;
endmodule

// File: tb/tb_main_mem_ctrl.sv
// Self-checking bench for main_mem_ctrl: directed scenarios followed by random reads/writes against an array model.
module tb_main_mem_ctrl;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int BW     = 4;
    localparam int LAT    = 4;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int BLK_W  = DATA_W * BW;

    logic clk = 1'b0;
    logic reset;

    main_mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLOCK_WORDS(BW)) bus ();

    main_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLOCK_WORDS(BW), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [BLK_W-1:0]  model_block;

    task automatic check(input string tag, input logic [BLK_W-1:0] got, input logic [BLK_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [BLK_W-1:0] fill(input int a);
        logic [BLK_W-1:0] r;
        int base;
        base = a - (a % BW);
        r = '0;
        for (int k = 0; k < BW; k++) r[k*DATA_W +: DATA_W] = model_mem[base + k];
        return r;
    endfunction

    task automatic clear_inputs();
        bus.rd_req  = 1'b0;
        bus.wr_req  = 1'b0;
        bus.addr    = '0;
        bus.wr_data = '0;
    endtask

    // One request presented for a single cycle from IDLE; optional junk requests while busy.
    task automatic do_op(input bit rd, input bit wr, input int a, input logic [DATA_W-1:0] d, input bit noise);
        @(negedge clk);
        check("idle_busy", bus.busy, 1'b0);
        check("idle_ready", bus.ready, 1'b0);
        bus.rd_req  = rd;
        bus.wr_req  = wr;
        bus.addr    = ADDR_W'(a);
        bus.wr_data = d;
        @(posedge clk);
        #1;
        if (noise) begin
            bus.rd_req  = 1'b1;
            bus.wr_req  = 1'($urandom_range(0, 1));
            bus.addr    = ADDR_W'($urandom);
            bus.wr_data = $urandom;
        end else begin
            clear_inputs();
        end
        for (int c = 0; c < LAT; c++) begin
            @(negedge clk);
            check("busy_high", bus.busy, 1'b1);
            check("ready_early", bus.ready, 1'b0);
        end
        @(negedge clk);
        clear_inputs();
        check("ready_pulse", bus.ready, 1'b1);
        check("busy_low", bus.busy, 1'b0);
        if (wr) model_mem[a] = d;
        else    model_block = fill(a);
        check(wr ? "block_after_wr" : "block_after_rd", bus.rd_block, model_block);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = DATA_W'(i);
        model_block = '0;
        reset = 1'b0;
        clear_inputs();

        // Reset state
        #1;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_ready", bus.ready, 1'b0);
        check("rst_block", bus.rd_block, '0);
        repeat (2) @(negedge clk);
        check("rst_hold_ready", bus.ready, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_ready", bus.ready, 1'b0);
        check("post_rst_busy", bus.busy, 1'b0);
        check("post_rst_block", bus.rd_block, '0);

        // Directed scenarios
        do_op(1'b1, 1'b0, 'h000, '0, 1'b0);
        check("blk0_literal", bus.rd_block, {32'd3, 32'd2, 32'd1, 32'd0});
        do_op(1'b1, 1'b0, 'h006, '0, 1'b1);
        check("blk4_literal", bus.rd_block, {32'd7, 32'd6, 32'd5, 32'd4});
        do_op(1'b0, 1'b1, 'h001, 32'hDEADBEEF, 1'b0);
        do_op(1'b1, 1'b0, 'h000, '0, 1'b0);
        check("blk0_after_wr", bus.rd_block, {32'd3, 32'd2, 32'hDEADBEEF, 32'd0});
        do_op(1'b1, 1'b1, 'h008, 32'hCAFEF00D, 1'b0);
        do_op(1'b1, 1'b0, 'h008, '0, 1'b0);
        check("blk8_after_both", bus.rd_block, {32'd11, 32'd10, 32'd9, 32'hCAFEF00D});

        // Reset aborts an in-flight write
        @(negedge clk);
        bus.wr_req  = 1'b1;
        bus.addr    = 10'h002;
        bus.wr_data = 32'h12345678;
        @(posedge clk);
        #1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_block = '0;
        #1;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_ready", bus.ready, 1'b0);
        check("abort_block", bus.rd_block, '0);
        repeat (2) @(negedge clk);
        check("abort_hold_ready", bus.ready, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_no_ready", bus.ready, 1'b0);
        do_op(1'b1, 1'b0, 'h000, '0, 1'b0);
        check("abort_word2", bus.rd_block[2*DATA_W +: DATA_W], 32'd2);

        // Random mix, biased toward a small window so reads see earlier writes
        for (int n = 0; n < 60; n++) begin
            int a;
            bit rd, wr;
            a  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, DEPTH - 1));
            wr = ($urandom_range(0, 2) == 0);
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            do_op(rd, wr, a, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/main_mem_ctrl.md
Name: main_mem_ctrl

Overview:
- Backing main memory behind the data cache. Services cache-miss block fills and write-through word stores with a fixed multi-cycle latency.
- Sits directly downstream of the cache controller inside the data memory subsystem.
- The cache controller holds its pipeline stall asserted while this block reports busy.

Parameters:
- ADDR_W, 10, word-address width; memory depth is 2**ADDR_W words.
- DATA_W, 32, word width in bits.
- BLOCK_WORDS, 4, words per cache block; must be a power of two, at least 1.
- LATENCY, 4, cycles from request acceptance to completion; minimum 1.

Ports:
- clk  in  1  system clock, rising-edge active.
- reset  in  1  asynchronous, active-low reset.
- rd_req  in  1  block-read request, level-sampled in IDLE.
- wr_req  in  1  word-write request, level-sampled in IDLE.
- addr  in  ADDR_W  word address of the request.
- wr_data  in  DATA_W  store data for wr_req.
- rd_block  out  DATA_W*BLOCK_WORDS  last completed fill block.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  request in progress.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, busy=0, ready=0, rd_block=0, latched request cleared.
  - The memory array is not touched by reset. At time zero it is initialised so that mem[i] = i (zero-extended).
- States: IDLE, RD_WAIT, WR_WAIT.
- IDLE, rising edge:
  - wr_req=1: latch addr and wr_data, go to WR_WAIT.
  - wr_req=0 and rd_req=1: latch addr with its low log2(BLOCK_WORDS) bits forced to 0, go to RD_WAIT.
  - Both asserted: the write wins and the read is dropped. The cache controller must re-issue the read.
  - The acceptance edge sets busy=1 and counter=1.
- RD_WAIT / WR_WAIT:
  - Counter increments each edge.
  - On the edge where counter==LATENCY, the operation completes, state returns to IDLE, busy=0 and ready=1 for exactly one cycle.
  - Result: busy is high for exactly LATENCY cycles and ready rises on the edge busy falls.
- Read completion: rd_block word k (bits [DATA_W*k+DATA_W-1 : DATA_W*k]) = mem[base+k] for k=0..BLOCK_WORDS-1. rd_block holds its value until the next read completion. Write completions and reset-free idle cycles do not change it.
- Write completion: mem[latched addr] = latched wr_data at the completion edge. Only that word is written; no alignment is applied.
- Requests while busy=1 are ignored, not queued. Inputs changing after acceptance have no effect.
- The cycle in which ready=1 has state=IDLE, so a new request present in that cycle is accepted at the next edge. Back-to-back throughput is one operation per LATENCY+1 cycles.
- Address wrap: none is possible, since the block base plus BLOCK_WORDS-1 never exceeds 2**ADDR_W-1 because of alignment.
- Reset mid-operation: aborts the operation immediately. A pending write is not performed, busy and ready go to 0, and rd_block is cleared.
- LATENCY=1: busy is high for one cycle, then ready pulses in the following cycle.
- The memory is written on clk only. Reads of mem are taken from the array at the completion edge and therefore reflect any write completed earlier.

Test Plan:
1. Hold reset=0 for 2 cycles, then release -> busy=0, ready=0, rd_block=0 during and after reset; no spurious ready.
2. rd_req=1, addr=10'h000 for one cycle in IDLE -> busy high 4 cycles, then ready pulse. rd_block = {32'd3, 32'd2, 32'd1, 32'd0} (word 0 in the LSBs).
3. rd_req=1, addr=10'h006 -> aligned base 4. rd_block = {32'd7, 32'd6, 32'd5, 32'd4}. A further rd_req at addr 10'h040 issued while busy is ignored: exactly one ready pulse.
4. wr_req=1, addr=10'h001, wr_data=32'hDEADBEEF -> ready after 4 cycles with rd_block unchanged. A subsequent read at addr 10'h000 returns {32'd3, 32'd2, 32'hDEADBEEF, 32'd0}.
5. rd_req=1 and wr_req=1 together, addr=10'h008, wr_data=32'hCAFEF00D -> write performed and rd_block unchanged. A later read at addr 10'h008 returns word 0 = 32'hCAFEF00D and words 1..3 = 9, 10, 11.
6. wr_req at addr 10'h002, data 32'h12345678, then reset=0 two cycles after acceptance -> busy=0 immediately and no ready. After release, a read at addr 10'h000 returns word 2 = 32'd2.
